// File: rtl/mvau_wmem_seq.sv
// mvau_wmem_seq: sweeps one PE lane's weight memory per repetition and streams words through a credit-guarded 2-entry FIFO
module mvau_wmem_seq #(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4,
    parameter int REP_BW       = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic [REP_BW-1:0]       num_reps,
    output logic                    busy,
    output logic                    done,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    input  logic [SIMD*TW-1:0]      wmem_out,
    output logic [SIMD*TW-1:0]      wgt_data,
    output logic                    wgt_valid,
    input  logic                    wgt_ready,
    output logic                    wgt_last
);
    localparam int W = SIMD * TW;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    logic [1:0]              state_q, state_d;
    logic [WMEM_ADDR_BW-1:0] addr_q, addr_d;
    logic [REP_BW-1:0]       rep_q, rep_d, reps_q, reps_d;
    logic                    iss_q, iss_d, iss_last_q, iss_last_d;
    logic                    done_q, done_d;
    logic [W-1:0]            d0_q, d0_d, d1_q, d1_d;
    logic                    l0_q, l0_d, l1_q, l1_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    pop, issue, at_last;
    logic [2:0]              credit;

    assign busy      = state_q != S_IDLE;
    assign done      = done_q;
    assign wmem_addr = addr_q;
    assign wgt_valid = cnt_q != 2'd0;
    assign wgt_data  = d0_q;
    assign wgt_last  = l0_q & wgt_valid;

    // Credit check: the read in flight plus the words held after this cycle's pop must leave a free slot
    always_comb begin
        pop     = wgt_valid & wgt_ready;
        credit  = {1'b0, cnt_q} + {2'b0, iss_q} - {2'b0, pop};
        issue   = (state_q == S_RUN) & (credit < 3'd2);
        at_last = addr_q == LAST_ADDR;
    end

    // Sequencer: address/repetition walk and IDLE/RUN/DRAIN transitions
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rep_d      = rep_q;
        reps_d     = reps_q;
        done_d     = 1'b0;
        iss_d      = issue;
        iss_last_d = issue & at_last;
        if (state_q == S_IDLE) begin
            if (start) begin
                done_d  = num_reps == '0;
                state_d = (num_reps == '0) ? S_IDLE : S_RUN;
                addr_d  = '0;
                rep_d   = '0;
                reps_d  = num_reps;
            end
        end else if (state_q == S_RUN) begin
            if (issue) begin
                addr_d  = at_last ? '0 : addr_q + 1'b1;
                rep_d   = at_last ? rep_q + 1'b1 : rep_q;
                state_d = (at_last && rep_q == reps_q - 1'b1) ? S_DRAIN : S_RUN;
            end
        end else if (cnt_d == 2'd0 && !iss_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end
    end

    // Output FIFO: slot 0 is the head; a returning read lands in the first slot left free after the pop
    always_comb begin
        d0_d  = d0_q;
        d1_d  = d1_q;
        l0_d  = l0_q;
        l1_d  = l1_q;
        cnt_d = cnt_q + {1'b0, iss_q} - {1'b0, pop};
        if (pop) begin
            d0_d = d1_q;
            l0_d = l1_q;
        end
        if (iss_q) begin
            if (cnt_q - {1'b0, pop} == 2'd0) begin
                d0_d = wmem_out;
                l0_d = iss_last_q;
            end else begin
                d1_d = wmem_out;
                l1_d = iss_last_q;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rep_q      <= '0;
            reps_q     <= '0;
            iss_q      <= 1'b0;
            iss_last_q <= 1'b0;
            done_q     <= 1'b0;
            d0_q       <= '0;
            d1_q       <= '0;
            l0_q       <= 1'b0;
            l1_q       <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rep_q      <= rep_d;
            reps_q     <= reps_d;
            iss_q      <= iss_d;
            iss_last_q <= iss_last_d;
            done_q     <= done_d;
            d0_q       <= d0_d;
            d1_q       <= d1_d;
            l0_q       <= l0_d;
            l1_q       <= l1_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule
